// File: rtl/mmio_pkg.sv
// -----------------------------------------------------------------------------
// mmio_pkg
//   Shared constants and helpers for the memory-mapped I/O responder that sits
//   beside the data RAM on the core's MEM-stage bus.
//   - MMIO_BASE     : byte address of the 64-byte register window
//   - WINDOW_BYTES  : size of the window in bytes
//   - OFF_*         : register offsets inside the window (8-byte aligned)
//   - reg_sel_e     : decoded register selector
//   - decode_offset : maps a 6-bit window offset to a register selector
// -----------------------------------------------------------------------------
package mmio_pkg;

   localparam logic [63:0] MMIO_BASE    = 64'h0000_0000_0000_1000;
   localparam int unsigned WINDOW_BYTES = 64;

   localparam logic [5:0] OFF_LEDS     = 6'h00;
   localparam logic [5:0] OFF_SWITCH   = 6'h08;
   localparam logic [5:0] OFF_SW_EDGE  = 6'h10;
   localparam logic [5:0] OFF_CYCLE    = 6'h18;
   localparam logic [5:0] OFF_DEBOUNCE = 6'h20;

   typedef enum logic [2:0] {
      REG_LEDS,
      REG_SWITCH,
      REG_SW_EDGE,
      REG_CYCLE,
      REG_DEBOUNCE,
      REG_RESERVED
   } reg_sel_e;

   // Offsets 0x28..0x38 (and any misaligned offset, which never produces a
   // hit anyway) fall through to the reserved slot.
   function automatic reg_sel_e decode_offset(input logic [5:0] offset);
      reg_sel_e sel;
      case (offset)
         OFF_LEDS:     sel = REG_LEDS;
         OFF_SWITCH:   sel = REG_SWITCH;
         OFF_SW_EDGE:  sel = REG_SW_EDGE;
         OFF_CYCLE:    sel = REG_CYCLE;
         OFF_DEBOUNCE: sel = REG_DEBOUNCE;
         default:      sel = REG_RESERVED;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/mmio_responder_switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
//   Brings raw asynchronous board switches into the clock domain through a
//   2-flop synchronizer, then debounces the whole vector with one shared
//   counter: a new candidate value must stay unchanged for `period` cycles
//   before it is committed as the stable value.
// Ports
//   clk     in   1      clock, all state on posedge
//   rst_n   in   1      asynchronous active-low reset
//   period  in   DB_W   required stable period in cycles (0 behaves as 1)
//   raw     in   W      raw asynchronous switch inputs
//   stable  out  W      debounced switch vector (registered)
//   rise    out  W      one-cycle mask of bits going 0->1 at the coming edge
// -----------------------------------------------------------------------------
module switch_debouncer #(
   parameter int unsigned W    = 18,
   parameter int unsigned DB_W = 20
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [DB_W-1:0] period,
   input  logic [W-1:0]    raw,
   output logic [W-1:0]    stable,
   output logic [W-1:0]    rise
);

   logic [W-1:0]    sync1_q;
   logic [W-1:0]    sync2_q;
   logic [W-1:0]    cand_q;
   logic [W-1:0]    stable_q;
   logic [DB_W-1:0] cnt_q;
   logic [DB_W-1:0] period_eff;
   logic            commit;

   assign period_eff = (period == '0) ? DB_W'(1) : period;

   // ">=" rather than "==" so that shrinking the period below the current
   // count still commits on the next edge instead of waiting for a wrap.
   assign commit = (sync2_q == cand_q) &&
                   (cnt_q >= period_eff - DB_W'(1)) &&
                   (cand_q != stable_q);

   // Rise is taken from the value about to be committed so the sticky edge
   // flags in the parent update on the same edge as the stable vector.
   assign rise   = commit ? (cand_q & ~stable_q) : '0;
   assign stable = stable_q;

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop regardless of order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         cand_q   <= '0;
         stable_q <= '0;
         cnt_q    <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         if (sync2_q != cand_q) begin
            cand_q <= sync2_q;
            cnt_q  <= '0;
         end else if (commit) begin
            stable_q <= cand_q;
         end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + DB_W'(1);
         end
      end
   end

endmodule

// File: rtl/mmio_responder.sv
// -----------------------------------------------------------------------------
// mmio_responder
//   Bus-side responder for MEM-stage loads/stores. Decodes a 64-byte window at
//   MMIO_BASE and serves LED, debounced switch, sticky switch-edge, cycle
//   counter and debounce-period registers. The data RAM must be deselected
//   whenever hit=1.
// Ports
//   clock       in   1      system clock, all state on posedge
//   reset       in   1      asynchronous active-low reset
//   MemRead     in   1      load in MEM stage this cycle
//   MemWrite    in   1      store in MEM stage this cycle
//   address     in   64     byte address (EX/MEM alu_result)
//   write_data  in   64     store data
//   read_data   out  64     load data, combinational; 0 unless hit && MemRead
//   hit         out  1      aligned access inside the window
//   switches    in   SW_W   raw asynchronous board switches
//   leds        out  LED_W  LED register contents
// Register map (offset, access)
//   0x00 LEDS RW | 0x08 SWITCH RO | 0x10 SW_EDGE W1C | 0x18 CYCLE RW (write
//   clears) | 0x20 DEBOUNCE RW | 0x28..0x38 reserved (read 0, writes ignored)
// -----------------------------------------------------------------------------
module mmio_responder #(
   parameter logic [63:0] MMIO_BASE  = mmio_pkg::MMIO_BASE,
   parameter int unsigned SW_W       = 18,
   parameter int unsigned LED_W      = 27,
   parameter int unsigned DB_W       = 20,
   parameter int unsigned DB_DEFAULT = 50000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             MemRead,
   input  logic             MemWrite,
   input  logic [63:0]      address,
   input  logic [63:0]      write_data,
   output logic [63:0]      read_data,
   output logic             hit,
   input  logic [SW_W-1:0]  switches,
   output logic [LED_W-1:0] leds
);

   import mmio_pkg::*;

   logic [63:0]      offset_full;
   logic             in_window;
   logic             aligned;
   logic             wr_en;
   reg_sel_e         sel;

   logic [LED_W-1:0] leds_q;
   logic [SW_W-1:0]  sw_edge_q;
   logic [63:0]      cycle_q;
   logic [DB_W-1:0]  debounce_q;

   logic [SW_W-1:0]  sw_stable;
   logic [SW_W-1:0]  sw_rise;
   logic [SW_W-1:0]  edge_clear;

   // Store data bits above each register's width have no destination.
   logic             unused_write_bits;
   assign unused_write_bits = ^write_data;

   // ---------------------------------------------------------------------------
   // Address decode. Subtracting the base (instead of comparing upper bits)
   // keeps the decode correct for any base, aligned to 64 bytes or not.
   // ---------------------------------------------------------------------------
   assign offset_full = address - MMIO_BASE;
   assign in_window   = offset_full < 64'(WINDOW_BYTES);
   assign aligned     = address[2:0] == 3'b000;
   assign hit         = in_window && aligned && (MemRead || MemWrite);
   assign sel         = decode_offset(offset_full[5:0]);
   assign wr_en       = hit && MemWrite;

   assign edge_clear  = (wr_en && sel == REG_SW_EDGE) ? write_data[SW_W-1:0] : '0;

   // ---------------------------------------------------------------------------
   // Switch synchronizer + debouncer
   // ---------------------------------------------------------------------------
   switch_debouncer #(
      .W    (SW_W),
      .DB_W (DB_W)
   ) u_debouncer (
      .clk    (clock),
      .rst_n  (reset),
      .period (debounce_q),
      .raw    (switches),
      .stable (sw_stable),
      .rise   (sw_rise)
   );

   // ---------------------------------------------------------------------------
   // Registers. Writes land on the edge that ends the MEM cycle.
   // ---------------------------------------------------------------------------
   // NOTE: every register here is a plain flop with a defined reset value;
   // there is no storage array, so nothing is left uninitialised after reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         leds_q     <= '0;
         sw_edge_q  <= '0;
         cycle_q    <= '0;
         debounce_q <= DB_W'(DB_DEFAULT);
      end else begin
         // Clearing write has priority over the free-running increment.
         if (wr_en && sel == REG_CYCLE) begin
            cycle_q <= '0;
         end else begin
            cycle_q <= cycle_q + 64'd1;
         end

         if (wr_en && sel == REG_LEDS) begin
            leds_q <= write_data[LED_W-1:0];
         end

         if (wr_en && sel == REG_DEBOUNCE) begin
            debounce_q <= write_data[DB_W-1:0];
         end

         // A new rising edge wins over a W1C of the same bit.
         sw_edge_q <= (sw_edge_q & ~edge_clear) | sw_rise;
      end
   end

   assign leds = leds_q;

   // ---------------------------------------------------------------------------
   // Read mux: zero-latency, from current (pre-write) register state.
   // ---------------------------------------------------------------------------
   // NOTE: read_data gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      read_data = '0;
      if (hit && MemRead) begin
         case (sel)
            REG_LEDS:     read_data = 64'(leds_q);
            REG_SWITCH:   read_data = 64'(sw_stable);
            REG_SW_EDGE:  read_data = 64'(sw_edge_q);
            REG_CYCLE:    read_data = cycle_q;
            REG_DEBOUNCE: read_data = 64'(debounce_q);
            default:      read_data = '0;
         endcase
      end
   end

endmodule
